// File: rtl/spart.sv
// rtl/spart.sv - bus-mapped 8N1 UART with programmable baud divisor; SPART_OVERRUN_EN adds the ovr status flag
`timescale 1ns/1ps
module spart #(
  parameter logic [15:0] DB_RESET = 16'd325
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  localparam logic [0:0] TX_IDLE  = 1'b0;
  localparam logic [0:0] TX_SHIFT = 1'b1;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [15:0] r_db;
  logic [15:0] r_cnt;
  logic [0:0]  r_tx_state;
  logic [9:0]  r_tx_shift;
  logic [3:0]  r_tx_bit;
  logic [3:0]  r_tx_en_cnt;
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_s3;
  logic [1:0]  r_rx_state;
  logic [3:0]  r_rx_en_cnt;
  logic [2:0]  r_rx_bits;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_rx_buf;
  logic        r_rda;

  logic        w_wr;
  logic        w_rd;
  logic        w_wr_tx;
  logic        w_wr_dbl;
  logic        w_wr_dbh;
  logic        w_rd_rx;
  logic        w_rd_st;
  logic [15:0] w_db_next;
  logic        w_en;
  logic        w_rx_bit;
  logic        w_rx_fall;
  logic        w_rx_done;
  logic        w_ovr;
  logic        w_drive;
  logic [7:0]  w_rdata;

  // Register bus decode
  assign w_wr      = iocs & ~iorw;
  assign w_rd      = iocs & iorw;
  assign w_wr_tx   = w_wr & (ioaddr == 2'b00);
  assign w_wr_dbl  = w_wr & (ioaddr == 2'b10);
  assign w_wr_dbh  = w_wr & (ioaddr == 2'b11);
  assign w_rd_rx   = w_rd & (ioaddr == 2'b00);
  assign w_rd_st   = w_rd & (ioaddr == 2'b01);
  assign w_db_next = w_wr_dbl ? {r_db[15:8], databus} : {databus, r_db[7:0]};

  // Only reads of the RX buffer and status drive the shared bus
  assign w_drive = w_rd & ~ioaddr[1];
  assign w_rdata = ioaddr[0] ? {5'b0, w_ovr, tbr, rda} : r_rx_buf;
  assign databus = w_drive ? w_rdata : 8'bz;

  // Divisor buffer, written one byte at a time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db <= DB_RESET;
    end else if (w_wr_dbl || w_wr_dbh) begin
      r_db <= w_db_next;
    end
  end

  // Baud down-counter: en on zero, reload from DB; a divisor write restarts it immediately
  assign w_en = (r_cnt == 16'd0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= DB_RESET;
    end else if (w_wr_dbl || w_wr_dbh) begin
      r_cnt <= w_db_next;
    end else if (w_en) begin
      r_cnt <= r_db;
    end else begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  // Transmitter: shifts {stop, data, start} LSB-first, 16 en per bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state  <= TX_IDLE;
      r_tx_shift  <= 10'h3FF;
      r_tx_bit    <= 4'd0;
      r_tx_en_cnt <= 4'd0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_wr_tx) begin
            r_tx_shift  <= {1'b1, databus, 1'b0};
            r_tx_bit    <= 4'd0;
            r_tx_en_cnt <= 4'd0;
            r_tx_state  <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (w_en) begin
            r_tx_en_cnt <= r_tx_en_cnt + 4'd1;
            if (r_tx_en_cnt == 4'd15) begin
              if (r_tx_bit == 4'd9) begin
                r_tx_state <= TX_IDLE;
              end else begin
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                r_tx_bit   <= r_tx_bit + 4'd1;
              end
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign tbr = (r_tx_state == TX_IDLE);
  assign txd = (r_tx_state == TX_IDLE) ? 1'b1 : r_tx_shift[0];

  // rxd synchronizer plus one extra stage for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= rxd;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  assign w_rx_bit  = r_rx_s2;
  assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

  // Receiver: start checked mid-bit (8 en), then data and stop every 16 en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state  <= RX_IDLE;
      r_rx_en_cnt <= 4'd0;
      r_rx_bits   <= 3'd0;
      r_rx_shift  <= 8'h00;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_state  <= RX_START;
            r_rx_en_cnt <= 4'd0;
          end
        end
        RX_START: begin
          if (w_en) begin
            if (r_rx_en_cnt == 4'd7) begin
              r_rx_en_cnt <= 4'd0;
              r_rx_bits   <= 3'd0;
              r_rx_state  <= w_rx_bit ? RX_IDLE : RX_DATA;
            end else begin
              r_rx_en_cnt <= r_rx_en_cnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (w_en) begin
            r_rx_en_cnt <= r_rx_en_cnt + 4'd1;
            if (r_rx_en_cnt == 4'd15) begin
              r_rx_shift <= {w_rx_bit, r_rx_shift[7:1]};
              r_rx_bits  <= r_rx_bits + 3'd1;
              if (r_rx_bits == 3'd7) begin
                r_rx_state <= RX_STOP;
              end
            end
          end
        end
        RX_STOP: begin
          if (w_en) begin
            r_rx_en_cnt <= r_rx_en_cnt + 4'd1;
            if (r_rx_en_cnt == 4'd15) begin
              r_rx_state <= RX_IDLE;
            end
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // A good stop bit completes the byte; a framing error leaves buffer and rda alone
  assign w_rx_done = (r_rx_state == RX_STOP) & w_en & (r_rx_en_cnt == 4'd15) & w_rx_bit;

  // RX buffer and rda: a completing byte beats a simultaneous buffer read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rda    <= 1'b0;
      r_rx_buf <= 8'h00;
    end else if (w_rx_done) begin
      r_rda    <= 1'b1;
      r_rx_buf <= r_rx_shift;
    end else if (w_rd_rx) begin
      r_rda    <= 1'b0;
    end
  end

  assign rda = r_rda;

`ifdef SPART_OVERRUN_EN
  logic r_ovr;

  // Overrun flag: set when an unread byte is overwritten, cleared by a status read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr <= 1'b0;
    end else if (w_rx_done && r_rda) begin
      r_ovr <= 1'b1;
    end else if (w_rd_st) begin
      r_ovr <= 1'b0;
    end
  end

  assign w_ovr = r_ovr;
`else
  assign w_ovr = 1'b0;
`endif

endmodule

// File: tb/tb_spart.sv
// tb/tb_spart.sv - scoreboard testbench for spart
`timescale 1ns/1ps
module tb_spart;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda;
  logic       tbr;
  logic       txd;
  wire        rxd;

  logic [7:0] r_wdata;
  logic       r_drv;
  logic       r_rxd;
  logic       r_loop;

  assign databus = r_drv ? r_wdata : 8'bz;
  assign rxd     = r_loop ? txd : r_rxd;

  spart #(.DB_RESET(16'd325)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr),
    .txd     (txd),
    .rxd     (rxd)
  );

  always #5 clk = ~clk;

`ifdef SPART_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] tx_q[$];

  int         n_cmp;
  int         n_err;
  int         rst_epoch;
  int         m_db;
  bit         m_rda;
  bit         m_ovr;
  bit         m_tbr;
  logic [7:0] m_buf;
  bit         sim_got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle();
    @(negedge clk);
    iocs  = 1'b0;
    iorw  = 1'b1;
    ioaddr = 2'd0;
    r_drv = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs    = 1'b1;
    iorw    = 1'b0;
    ioaddr  = a;
    r_wdata = d;
    r_drv   = 1'b1;
    bus_idle();
  endtask

  // Expected read value comes from the model; side effects applied afterwards
  task automatic rd(input logic [1:0] a);
    exp_t e;
    e.addr = a;
    e.data = (a == 2'd0) ? m_buf : {5'b0, m_ovr, m_tbr, m_rda};
    sb_q.push_back(e);
    if (a == 2'd0) m_rda = 1'b0;
    else           m_ovr = 1'b0;
    @(negedge clk);
    iocs   = 1'b1;
    iorw   = 1'b1;
    ioaddr = a;
    r_drv  = 1'b0;
    bus_idle();
  endtask

  task automatic set_db(input int d);
    wr(2'd2, 8'(d));
    wr(2'd3, 8'(d >> 8));
    m_db = d;
  endtask

  task automatic model_rx(input logic [7:0] b);
    if (m_rda && OVR_EN) m_ovr = 1'b1;
    m_rda = 1'b1;
    m_buf = b;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input bit upd);
    int         tbt;
    logic [9:0] f;
    tbt = 16 * (m_db + 1);
    f   = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      r_rxd = f[i];
      repeat (tbt - 1) @(negedge clk);
    end
    @(negedge clk);
    r_rxd = 1'b1;
    repeat (4) @(negedge clk);
    if (upd && stop) model_rx(b);
  endtask

  task automatic tx(input logic [7:0] b);
    tx_q.push_back(b);
    m_tbr = 1'b0;
    wr(2'd0, b);
  endtask

  task automatic tx_done();
    idle(160 * (m_db + 1) + 3);
    m_tbr = 1'b1;
    chk("tx_tbr_back", 32'(tbr), 32'd1);
  endtask

  // Bus monitor: every RX-buffer or status read is checked against the scoreboard
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    if (iocs && iorw && !ioaddr[1]) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL bus_read_unexpected: addr %0d data %0h", ioaddr, databus);
      end else begin
        e = sb_q.pop_front();
        chk("bus_read", 32'({ioaddr, databus}), 32'({e.addr, e.data}));
      end
    end
  end

  // Serial monitor: decodes txd frames at the model bit time and checks them in order
  initial begin : tx_mon
    logic       prev;
    logic [9:0] bits;
    logic [7:0] e;
    int         tbt;
    int         ep;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !txd && rst_n) begin
        ep  = rst_epoch;
        tbt = 16 * (m_db + 1);
        repeat (tbt / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          bits[i] = txd;
          if (i < 9) repeat (tbt) @(negedge clk);
        end
        if (ep == rst_epoch) begin
          if (tx_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL tx_frame_unexpected: bits %0h", bits);
          end else begin
            e = tx_q.pop_front();
            chk("tx_frame", 32'(bits), 32'({1'b1, e, 1'b0}));
          end
        end
      end
      prev = txd;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; rst_epoch = 0;
    iocs = 1'b0; iorw = 1'b1; ioaddr = 2'd0; r_drv = 1'b0; r_wdata = 8'h00;
    r_rxd = 1'b1; r_loop = 1'b0;
    m_db = 325; m_rda = 1'b0; m_ovr = 1'b0; m_tbr = 1'b1; m_buf = 8'h00;
    rst_n = 1'b0;
    idle(3);
    chk("reset_txd", 32'(txd), 32'd1);
    chk("reset_tbr", 32'(tbr), 32'd1);
    chk("reset_rda", 32'(rda), 32'd0);
    rst_n = 1'b1;
    rd(2'd1);

    // Receive a byte, start a frame, then reset in the middle of it
    set_db(3);
    send_frame(8'h3C, 1'b1, 1'b1);
    chk("rx_rda_set", 32'(rda), 32'd1);
    wr(2'd0, 8'h77);
    idle(100);
    rst_n = 1'b0;
    rst_epoch++;
    #1;
    chk("midtx_reset_txd", 32'(txd), 32'd1);
    chk("midtx_reset_tbr", 32'(tbr), 32'd1);
    chk("midtx_reset_rda", 32'(rda), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_db = 325; m_rda = 1'b0; m_ovr = 1'b0; m_tbr = 1'b1; m_buf = 8'h00;
    rd(2'd1);
    rd(2'd0);
    idle(700);

    // DB=3: 64-cycle bits, 8'hA5 frame
    set_db(3);
    tx(8'hA5);
    chk("a5_txd_start", 32'(txd), 32'd0);
    chk("a5_tbr_low", 32'(tbr), 32'd0);
    idle(619);
    chk("a5_tbr_still_low", 32'(tbr), 32'd0);
    idle(25);
    m_tbr = 1'b1;
    chk("a5_tbr_back", 32'(tbr), 32'd1);

    // Loopback of 8'h5A
    r_loop = 1'b1;
    tx(8'h5A);
    tx_done();
    model_rx(8'h5A);
    rd(2'd0);
    chk("loop_rda_clear", 32'(rda), 32'd0);
    r_loop = 1'b0;

    // Quarter-bit glitch must not produce a byte
    @(negedge clk);
    r_rxd = 1'b0;
    idle(16);
    r_rxd = 1'b1;
    idle(128);
    chk("glitch_no_rda", 32'(rda), 32'd0);
    rd(2'd1);

    // Framing error leaves buffer and rda untouched
    send_frame(8'hC3, 1'b0, 1'b1);
    chk("framing_no_rda", 32'(rda), 32'd0);
    rd(2'd1);
    rd(2'd0);

    // Write while busy is ignored
    tx(8'h96);
    idle(200);
    chk("busy_tbr_low", 32'(tbr), 32'd0);
    wr(2'd0, 8'h69);
    tx_done();

    // Overrun: two bytes without a read, status sampled with a frame in flight
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    tx(8'h3F);
    rd(2'd1);
    rd(2'd0);
    rd(2'd1);
    tx_done();

    // Byte completion coincident with an RX-buffer read
    set_db(0);
    sim_got = 1'b0;
    fork
      send_frame(8'hE7, 1'b1, 1'b0);
      begin
        exp_t e;
        idle(140);
        for (int k = 0; k < 40 && !sim_got; k++) begin
          @(negedge clk);
          if (k > 0 && rda) begin
            sim_got = 1'b1;
            iocs    = 1'b0;
          end else begin
            e.addr = 2'd0;
            e.data = m_buf;
            sb_q.push_back(e);
            m_rda  = 1'b0;
            iocs   = 1'b1;
            iorw   = 1'b1;
            ioaddr = 2'd0;
          end
        end
        if (!sim_got) bus_idle();
        chk("coincident_rda_kept", 32'(sim_got), 32'd1);
      end
    join
    model_rx(8'hE7);
    rd(2'd0);

    // Randomized traffic against the model
    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 4))
        0, 1: send_frame(8'($urandom), ($urandom_range(0, 5) != 0), 1'b1);
        2: begin
          tx(8'($urandom));
          tx_done();
        end
        3: rd(2'($urandom_range(0, 1)));
        default: set_db(int'($urandom_range(0, 4)));
      endcase
    end
    rd(2'd1);
    rd(2'd0);
    idle(5);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    chk("tx_queue_drained", 32'(tx_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
